bp_me_nonsynth_lce_req_tracker: RTL and testbench

Non-synthesisable monitor that sits directly upstream of the LCE tracer. It watches one LCE's request and inbound command handshakes and detects when the outstanding request is satisfied. It then produces the cache_req_complete / uc_store_req_complete pulses and the measured latency that the tracer logs. It also keeps running latency statistics plus sticky protocol-error and timeout flags for the bench.

---
 rtl/bp_common_pkg.sv | 28 ++
 rtl/bp_me_nonsynth_pkg.sv | 31 +++
 rtl/bp_me_nonsynth_lce_lat_stats.sv | 32 +++
 rtl/bp_me_nonsynth_lce_req_tracker.sv | 109 ++++++++++
 tb/tb_bp_me_nonsynth_lce_req_tracker.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/bp_common_pkg.sv
// BedRock LCE request and command message-type encodings shared across the memory-end monitors.
package bp_common_pkg;

  typedef enum logic [2:0] {
    e_bedrock_req_rd_miss = 3'b000,
    e_bedrock_req_wr_miss = 3'b001,
    e_bedrock_req_uc_rd   = 3'b010,
    e_bedrock_req_uc_wr   = 3'b011,
    e_bedrock_req_uc_amo  = 3'b100
  } bp_bedrock_req_type_e;

  typedef enum logic [3:0] {
    e_bedrock_cmd_sync       = 4'b0000,
    e_bedrock_cmd_set_clear  = 4'b0001,
    e_bedrock_cmd_inv        = 4'b0010,
    e_bedrock_cmd_st         = 4'b0011,
    e_bedrock_cmd_data       = 4'b0100,
    e_bedrock_cmd_st_wakeup  = 4'b0101,
    e_bedrock_cmd_wb         = 4'b0110,
    e_bedrock_cmd_st_wb      = 4'b0111,
    e_bedrock_cmd_tr         = 4'b1000,
    e_bedrock_cmd_st_tr      = 4'b1001,
    e_bedrock_cmd_st_tr_wb   = 4'b1010,
    e_bedrock_cmd_uc_data    = 4'b1011,
    e_bedrock_cmd_uc_st_done = 4'b1100
  } bp_bedrock_cmd_type_e;

endpackage

// File: rtl/bp_me_nonsynth_pkg.sv
// Tracker state, completion classes and the request/command matching helpers.
package bp_me_nonsynth_pkg;
  import bp_common_pkg::*;

  typedef enum logic [1:0] {e_idle, e_wait, e_done} tracker_state_e;

  typedef enum logic [1:0] {e_cls_cached, e_cls_uc_load, e_cls_uc_store} cmpl_class_e;

  function automatic cmpl_class_e req_class(input logic [2:0] req_type);
    cmpl_class_e cls;
    case (bp_bedrock_req_type_e'(req_type))
      e_bedrock_req_uc_rd,
      e_bedrock_req_uc_amo: cls = e_cls_uc_load;
      e_bedrock_req_uc_wr:  cls = e_cls_uc_store;
      default:              cls = e_cls_cached;
    endcase
    return cls;
  endfunction

  function automatic logic cmd_completes(input cmpl_class_e cls, input logic [3:0] cmd_type);
    logic hit;
    case (cls)
      e_cls_cached:   hit = (cmd_type == e_bedrock_cmd_data) || (cmd_type == e_bedrock_cmd_st_wakeup);
      e_cls_uc_load:  hit = (cmd_type == e_bedrock_cmd_uc_data);
      e_cls_uc_store: hit = (cmd_type == e_bedrock_cmd_uc_st_done);
      default:        hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/bp_me_nonsynth_lce_lat_stats.sv
// Running latency statistics: completed count, min, max and a saturating total.
module bp_me_nonsynth_lce_lat_stats #(
  parameter int cnt_width_p = 32
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   v_i,
  input  logic [cnt_width_p-1:0] latency_i,
  output logic [cnt_width_p-1:0] req_count_o,
  output logic [cnt_width_p-1:0] min_lat_o,
  output logic [cnt_width_p-1:0] max_lat_o,
  output logic [cnt_width_p-1:0] total_lat_o
);

  logic [cnt_width_p:0] sum;
  assign sum = {1'b0, total_lat_o} + {1'b0, latency_i};

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      req_count_o <= '0;
      min_lat_o   <= '1;
      max_lat_o   <= '0;
      total_lat_o <= '0;
    end else if (v_i) begin
      req_count_o <= req_count_o + 1'b1;
      if (latency_i < min_lat_o) min_lat_o <= latency_i;
      if (latency_i > max_lat_o) max_lat_o <= latency_i;
      total_lat_o <= sum[cnt_width_p] ? '1 : sum[cnt_width_p-1:0];
    end
  end

endmodule

// File: rtl/bp_me_nonsynth_lce_req_tracker.sv
// Watches one LCE's request/command handshakes and pulses completion with measured latency.
//   state  | meaning
//   e_idle | no request outstanding
//   e_wait | request latched, counting cycles until a matching command
//   e_done | one-cycle completion; stats update here
module bp_me_nonsynth_lce_req_tracker #(
  parameter int lce_id_width_p = 2,
  parameter int paddr_width_p  = 40,
  parameter int block_offset_p = 6,
  parameter int cnt_width_p    = 32,
  parameter int timeout_p      = 16384
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [lce_id_width_p-1:0] lce_id_i,
  input  logic                      req_v_i,
  input  logic                      req_ready_and_i,
  input  logic [2:0]                req_msg_type_i,
  input  logic [paddr_width_p-1:0]  req_addr_i,
  input  logic                      cmd_v_i,
  input  logic                      cmd_ready_and_i,
  input  logic [3:0]                cmd_msg_type_i,
  input  logic [paddr_width_p-1:0]  cmd_addr_i,
  input  logic [lce_id_width_p-1:0] cmd_dst_id_i,
  output logic                      cache_req_complete_o,
  output logic                      uc_store_req_complete_o,
  output logic [cnt_width_p-1:0]    latency_o,
  output logic                      busy_o,
  output logic [cnt_width_p-1:0]    req_count_o,
  output logic [cnt_width_p-1:0]    min_lat_o,
  output logic [cnt_width_p-1:0]    max_lat_o,
  output logic [cnt_width_p-1:0]    total_lat_o,
  output logic                      error_o,
  output logic                      timeout_o
);
  import bp_me_nonsynth_pkg::*;

  localparam logic [cnt_width_p-1:0] timeout_lp = cnt_width_p'(timeout_p);

  tracker_state_e             state;
  cmpl_class_e                cls;
  logic [paddr_width_p-1:0]   addr_r;
  logic [cnt_width_p-1:0]     cnt;

  logic req_fire, cmd_fire, addr_match, completes;

  assign req_fire = req_v_i & req_ready_and_i;
  assign cmd_fire = cmd_v_i & cmd_ready_and_i & (cmd_dst_id_i == lce_id_i);

  // cached requests are satisfied by any fill of the same block
  assign addr_match = (cls == e_cls_cached)
                    ? (cmd_addr_i[paddr_width_p-1:block_offset_p] == addr_r[paddr_width_p-1:block_offset_p])
                    : (cmd_addr_i == addr_r);
  assign completes  = cmd_fire & addr_match & cmd_completes(cls, cmd_msg_type_i);

  assign busy_o = (state != e_idle);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state                   <= e_idle;
      cls                     <= e_cls_cached;
      addr_r                  <= '0;
      cnt                     <= '0;
      latency_o               <= '0;
      cache_req_complete_o    <= 1'b0;
      uc_store_req_complete_o <= 1'b0;
      error_o                 <= 1'b0;
      timeout_o               <= 1'b0;
    end else begin
      cache_req_complete_o    <= 1'b0;
      uc_store_req_complete_o <= 1'b0;
      if (req_fire && (state != e_idle)) error_o <= 1'b1;
      case (state)
        e_idle: begin
          if (req_fire) begin
            cls    <= req_class(req_msg_type_i);
            addr_r <= req_addr_i;
            cnt    <= cnt_width_p'(1);
            state  <= e_wait;
          end
        end
        e_wait: begin
          if (cnt != '1) cnt <= cnt + 1'b1;
          if (cnt == timeout_lp) timeout_o <= 1'b1;
          if (completes) begin
            latency_o               <= cnt;
            state                   <= e_done;
            cache_req_complete_o    <= 1'b1;
            uc_store_req_complete_o <= (cls == e_cls_uc_store);
          end
        end
        e_done:  state <= e_idle;
        default: state <= e_idle;
      endcase
    end
  end

  bp_me_nonsynth_lce_lat_stats #(.cnt_width_p(cnt_width_p)) stats (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .v_i         (state == e_done),
    .latency_i   (latency_o),
    .req_count_o (req_count_o),
    .min_lat_o   (min_lat_o),
    .max_lat_o   (max_lat_o),
    .total_lat_o (total_lat_o)
  );

endmodule

// File: tb/tb_bp_me_nonsynth_lce_req_tracker.sv
// Self-checking bench: vector table plus hand sequences, completions checked through a scoreboard.
module tb_bp_me_nonsynth_lce_req_tracker;
  import bp_common_pkg::*;

  localparam int LW = 2, PW = 40, CW = 32, TO = 64;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b0;
  logic [LW-1:0] lce_id_i = '0;
  logic          req_v_i = 1'b0, req_ready_and_i = 1'b1;
  logic [2:0]    req_msg_type_i = '0;
  logic [PW-1:0] req_addr_i = '0;
  logic          cmd_v_i = 1'b0, cmd_ready_and_i = 1'b1;
  logic [3:0]    cmd_msg_type_i = '0;
  logic [PW-1:0] cmd_addr_i = '0;
  logic [LW-1:0] cmd_dst_id_i = '0;
  logic          cache_req_complete_o, uc_store_req_complete_o, busy_o, error_o, timeout_o;
  logic [CW-1:0] latency_o, req_count_o, min_lat_o, max_lat_o, total_lat_o;

  bp_me_nonsynth_lce_req_tracker #(
    .lce_id_width_p(LW), .paddr_width_p(PW), .block_offset_p(6),
    .cnt_width_p(CW), .timeout_p(TO)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .lce_id_i(lce_id_i),
    .req_v_i(req_v_i), .req_ready_and_i(req_ready_and_i),
    .req_msg_type_i(req_msg_type_i), .req_addr_i(req_addr_i),
    .cmd_v_i(cmd_v_i), .cmd_ready_and_i(cmd_ready_and_i),
    .cmd_msg_type_i(cmd_msg_type_i), .cmd_addr_i(cmd_addr_i), .cmd_dst_id_i(cmd_dst_id_i),
    .cache_req_complete_o(cache_req_complete_o), .uc_store_req_complete_o(uc_store_req_complete_o),
    .latency_o(latency_o), .busy_o(busy_o), .req_count_o(req_count_o),
    .min_lat_o(min_lat_o), .max_lat_o(max_lat_o), .total_lat_o(total_lat_o),
    .error_o(error_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  typedef struct { int cyc; int lat; logic uc; } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [2:0] rt; logic [PW-1:0] ra;
    logic [3:0] ct; logic [PW-1:0] ca;
    int n; logic uc;
  } vec_t;
  vec_t vecs[5];

  logic [CW-1:0] m_cnt, m_min, m_max, m_tot;

  task automatic model_reset();
    m_cnt = '0; m_min = '1; m_max = '0; m_tot = '0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (reset_i) begin
      if (cache_req_complete_o) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_pulse: got pulse at cycle %0d, expected none", cyc);
        end else begin
          exp_t e;
          longint s;
          e = sb.pop_front();
          chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
          chk("latency", 64'(latency_o), 64'(e.lat));
          chk("uc_store_pulse", 64'(uc_store_req_complete_o), 64'(e.uc));
          m_cnt = m_cnt + 1;
          if (CW'(e.lat) < m_min) m_min = CW'(e.lat);
          if (CW'(e.lat) > m_max) m_max = CW'(e.lat);
          s = longint'(m_tot) + longint'(e.lat);
          m_tot = (s > longint'(32'hFFFF_FFFF)) ? '1 : CW'(s);
        end
      end else if (uc_store_req_complete_o) begin
        checks++; errors++;
        $display("FAIL lone_uc_pulse: got uc pulse without cache pulse, expected both or none");
      end
    end
  end

  task automatic do_req(input logic [2:0] t, input logic [PW-1:0] a, output int fc);
    req_v_i = 1'b1; req_msg_type_i = t; req_addr_i = a;
    @(posedge clk_i); #1;
    fc = cyc;
    req_v_i = 1'b0;
  endtask

  task automatic send_cmd(input logic [3:0] t, input logic [PW-1:0] a, input logic [LW-1:0] dst,
                          input logic expect_done, input int fc, input logic uc);
    if (expect_done) sb.push_back('{cyc: cyc + 1, lat: cyc + 1 - fc, uc: uc});
    cmd_v_i = 1'b1; cmd_msg_type_i = t; cmd_addr_i = a; cmd_dst_id_i = dst;
    @(posedge clk_i); #1;
    cmd_v_i = 1'b0;
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(posedge clk_i); #2;
      k++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s: got %0d pending completions, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_count"}, 64'(req_count_o), 64'(m_cnt));
    chk({tag, "_min"},   64'(min_lat_o),   64'(m_min));
    chk({tag, "_max"},   64'(max_lat_o),   64'(m_max));
    chk({tag, "_total"}, 64'(total_lat_o), 64'(m_tot));
    chk({tag, "_busy"},  64'(busy_o),      64'd0);
  endtask

  initial begin
    int fc, fc2;

    vecs[0] = '{e_bedrock_req_rd_miss, 40'h00_8000_0040, e_bedrock_cmd_data,       40'h00_8000_0058, 12, 1'b0};
    vecs[1] = '{e_bedrock_req_uc_wr,   40'h00_0010_0000, e_bedrock_cmd_uc_st_done, 40'h00_0010_0000, 5,  1'b1};
    vecs[2] = '{e_bedrock_req_wr_miss, 40'h00_1234_5680, e_bedrock_cmd_st_wakeup,  40'h00_1234_56BF, 1,  1'b0};
    vecs[3] = '{e_bedrock_req_uc_rd,   40'h00_0000_0ABC, e_bedrock_cmd_uc_data,    40'h00_0000_0ABC, 3,  1'b0};
    vecs[4] = '{e_bedrock_req_uc_amo,  40'h00_0000_1000, e_bedrock_cmd_uc_data,    40'h00_0000_1000, 7,  1'b0};

    model_reset();
    #12;
    chk("rst_min", 64'(min_lat_o), 64'hFFFF_FFFF);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_flags", {62'd0, error_o, timeout_o}, 64'd0);
    chk("rst_count", 64'(req_count_o), 64'd0);
    @(posedge clk_i); #1;
    reset_i = 1'b1;
    @(posedge clk_i); #1;

    for (int i = 0; i < 5; i++) begin
      do_req(vecs[i].rt, vecs[i].ra, fc);
      chk($sformatf("vec%0d_busy", i), 64'(busy_o), 64'd1);
      repeat (vecs[i].n - 1) @(posedge clk_i);
      if (vecs[i].n > 1) #1;
      send_cmd(vecs[i].ct, vecs[i].ca, '0, 1'b1, fc, vecs[i].uc);
      drain($sformatf("vec%0d_drain", i));
      chk_stats($sformatf("vec%0d", i));
    end

    // request and matching command in the same cycle, then filtered commands
    req_v_i = 1'b1; req_msg_type_i = e_bedrock_req_rd_miss; req_addr_i = 40'h40;
    cmd_v_i = 1'b1; cmd_msg_type_i = e_bedrock_cmd_data; cmd_addr_i = 40'h58; cmd_dst_id_i = '0;
    @(posedge clk_i); #1;
    fc = cyc;
    req_v_i = 1'b0; cmd_v_i = 1'b0;
    send_cmd(e_bedrock_cmd_inv,     40'h40, 2'd0, 1'b0, fc, 1'b0);
    send_cmd(e_bedrock_cmd_data,    40'h80, 2'd0, 1'b0, fc, 1'b0);
    send_cmd(e_bedrock_cmd_data,    40'h40, 2'd1, 1'b0, fc, 1'b0);
    send_cmd(e_bedrock_cmd_uc_data, 40'h40, 2'd0, 1'b0, fc, 1'b0);
    chk("filter_busy", 64'(busy_o), 64'd1);
    send_cmd(e_bedrock_cmd_data,    40'h40, 2'd0, 1'b1, fc, 1'b0);
    drain("filter_drain");
    chk_stats("filter");
    chk("filter_no_error", 64'(error_o), 64'd0);

    // timeout then late completion
    do_req(e_bedrock_req_rd_miss, 40'h2000, fc);
    repeat (63) @(posedge clk_i); #1;
    chk("timeout_before", 64'(timeout_o), 64'd0);
    @(posedge clk_i); #1;
    chk("timeout_set", 64'(timeout_o), 64'd1);
    repeat (15) @(posedge clk_i); #1;
    send_cmd(e_bedrock_cmd_data, 40'h2000, 2'd0, 1'b1, fc, 1'b0);
    drain("timeout_drain");
    chk_stats("timeout");
    chk("timeout_sticky", 64'(timeout_o), 64'd1);

    // second request while busy
    do_req(e_bedrock_req_rd_miss, 40'h200, fc);
    repeat (2) @(posedge clk_i); #1;
    chk("perr_before", 64'(error_o), 64'd0);
    do_req(e_bedrock_req_uc_wr, 40'h300, fc2);
    chk("perr_set", 64'(error_o), 64'd1);
    send_cmd(e_bedrock_cmd_uc_st_done, 40'h300, 2'd0, 1'b0, fc, 1'b0);
    send_cmd(e_bedrock_cmd_data, 40'h200, 2'd0, 1'b1, fc, 1'b0);
    drain("perr_drain");
    chk_stats("perr");
    chk("perr_sticky", 64'(error_o), 64'd1);

    // asynchronous reset mid-wait
    do_req(e_bedrock_req_rd_miss, 40'h1000, fc);
    repeat (3) @(posedge clk_i); #3;
    reset_i = 1'b0;
    #1;
    model_reset();
    chk("arst_busy", 64'(busy_o), 64'd0);
    chk("arst_min", 64'(min_lat_o), 64'hFFFF_FFFF);
    chk("arst_flags", {62'd0, error_o, timeout_o}, 64'd0);
    chk("arst_count", 64'(req_count_o), 64'd0);
    chk("arst_latency", 64'(latency_o), 64'd0);
    @(posedge clk_i); #1;
    reset_i = 1'b1;
    do_req(e_bedrock_req_wr_miss, 40'h5000, fc);
    repeat (3) @(posedge clk_i); #1;
    send_cmd(e_bedrock_cmd_data, 40'h5000, 2'd0, 1'b1, fc, 1'b0);
    drain("arst_drain");
    chk_stats("arst");

    repeat (3) @(posedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
